// File: rtl/pe_layer_sequencer.sv
// Sequences one fully-connected layer through a single PE: bias fetch, header, weight/input stream, result write.
// Define SEQ_TIMEOUT_EN to add the WAIT watchdog and the err output.
module pe_layer_sequencer #(
  parameter int W_ADDR_W = 16,
  parameter int X_ADDR_W = 10,
  parameter int N_ADDR_W = 10,
  parameter int TIMEOUT  = 2048
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [9:0]          n_inputs,
  input  logic [N_ADDR_W-1:0] n_neurons,
  output logic [W_ADDR_W-1:0] w_addr,
  input  logic [31:0]         w_data,
  output logic [X_ADDR_W-1:0] x_addr,
  input  logic [31:0]         x_data,
  output logic [N_ADDR_W-1:0] b_addr,
  input  logic [31:0]         b_data,
  output logic [31:0]         pe_w,
  output logic [31:0]         pe_x,
  output logic [31:0]         pe_b,
  output logic                pe_head,
  input  logic [31:0]         pe_out,
  input  logic                pe_done,
  output logic                out_we,
  output logic [N_ADDR_W-1:0] out_addr,
  output logic [31:0]         out_data,
  output logic                busy,
  output logic                done
`ifdef SEQ_TIMEOUT_EN
  ,
  output logic                err
`endif
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETUP  = 3'd1;
  localparam logic [2:0] S_HEAD   = 3'd2;
  localparam logic [2:0] S_STREAM = 3'd3;
  localparam logic [2:0] S_WAIT   = 3'd4;
  localparam logic [2:0] S_WRITE  = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  localparam logic [N_ADDR_W-1:0] J_ONE = N_ADDR_W'(1);

  logic [2:0]          state_q, state_d;
  logic [9:0]          n_q, n_d, k_q, k_d;
  logic [N_ADDR_W-1:0] m_q, m_d, j_q, j_d;
  logic [W_ADDR_W-1:0] wa_q, wa_d;
  logic [31:0]         pb_q, pb_d, od_q, od_d;
  logic                zdone_q, zdone_d;

`ifdef SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            err_q, err_d;
`else
  // The watchdog limit still has to be referenced when the watchdog is compiled out.
  logic timeout_unused;
  assign timeout_unused = (TIMEOUT > 0);
`endif

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    m_d     = m_q;
    j_d     = j_q;
    k_d     = k_q;
    wa_d    = wa_q;
    pb_d    = pb_q;
    od_d    = od_q;
    zdone_d = 1'b0;
`ifdef SEQ_TIMEOUT_EN
    wd_d    = wd_q;
    err_d   = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
`ifdef SEQ_TIMEOUT_EN
          err_d = 1'b0;
`endif
          // An empty layer only acknowledges, without ever raising busy.
          if (n_neurons == '0) begin
            zdone_d = 1'b1;
          end else begin
            n_d     = n_inputs;
            m_d     = n_neurons;
            j_d     = '0;
            wa_d    = '0;
            state_d = S_SETUP;
          end
        end
      end
      S_SETUP: state_d = S_HEAD;
      S_HEAD: begin
        k_d     = '0;
        pb_d    = b_data;
`ifdef SEQ_TIMEOUT_EN
        wd_d    = '0;
`endif
        state_d = (n_q == '0) ? S_WAIT : S_STREAM;
      end
      S_STREAM: begin
        wa_d = wa_q + W_ADDR_W'(1);
        k_d  = k_q + 10'd1;
        if (k_q == n_q - 10'd1) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (pe_done) begin
          od_d    = pe_out;
          state_d = S_WRITE;
        end
`ifdef SEQ_TIMEOUT_EN
        else if (wd_q == WD_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
`endif
      end
      S_WRITE: begin
        if (j_q == m_q - J_ONE) begin
          state_d = S_DONE;
        end else begin
          j_d     = j_q + J_ONE;
          state_d = S_SETUP;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      m_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      wa_q    <= '0;
      pb_q    <= '0;
      od_q    <= '0;
      zdone_q <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
      wd_q    <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      m_q     <= m_d;
      j_q     <= j_d;
      k_q     <= k_d;
      wa_q    <= wa_d;
      pb_q    <= pb_d;
      od_q    <= od_d;
      zdone_q <= zdone_d;
`ifdef SEQ_TIMEOUT_EN
      wd_q    <= wd_d;
      err_q   <= err_d;
`endif
    end
  end

  // While streaming, addresses run one element ahead so data lines up with the next cycle.
  assign w_addr   = (state_q == S_STREAM) ? wa_q + W_ADDR_W'(1) : wa_q;
  assign x_addr   = (state_q == S_STREAM) ? X_ADDR_W'(k_q + 10'd1) : '0;
  assign b_addr   = j_q;
  assign out_addr = j_q;
  assign pe_head  = (state_q == S_HEAD);
  assign pe_w     = (state_q == S_STREAM) ? w_data : '0;
  assign pe_x     = (state_q == S_HEAD)   ? {22'b0, n_q} :
                    (state_q == S_STREAM) ? x_data : '0;
  assign pe_b     = (state_q == S_HEAD) ? b_data : pb_q;
  assign out_we   = (state_q == S_WRITE);
  assign out_data = od_q;
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE) | zdone_q;
`ifdef SEQ_TIMEOUT_EN
  assign err      = err_q;
`endif

endmodule
